// File: rtl/imem_loader.sv
// Streams a byte-wise program image (16-bit LE word count, then LE words) into imem, holding the core while loading.
// One write per word, wr_en one cycle after the 4th byte; in_valid gaps stall the loader indefinitely.
module imem_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       words_loaded
);

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, BYTE, WRITE, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [15:0]       count;
  logic [15:0]       count_full;
  logic [1:0]        idx;
  logic [23:0]       word;
  logic [ADDR_W-1:0] addr;
  logic              hs;
  logic              oversize;
  logic              last_word;

  assign hs         = in_valid && in_ready;
  assign count_full = {in_data, count[7:0]};
  assign oversize   = 32'(count_full) > 32'(DEPTH);
  assign last_word  = 32'(addr) == (32'(count) - 32'd1);
  assign cpu_hold   = busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    wr_en     = 1'b0;
    done      = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = HDR0;
      end
      HDR0: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = HDR1;
      end
      HDR1: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (count_full == 16'd0) state_nxt = DONE;
          else if (oversize)       state_nxt = IDLE;
          else                     state_nxt = BYTE;
        end
      end
      BYTE: begin
        in_ready = 1'b1;
        if (in_valid && idx == 2'd3) state_nxt = WRITE;
      end
      WRITE: begin
        wr_en     = 1'b1;
        state_nxt = last_word ? DONE : BYTE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output word/address are captured only when a word completes, so they stay put between writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count        <= '0;
      idx          <= '0;
      word         <= '0;
      addr         <= '0;
      wr_addr      <= '0;
      wr_data      <= '0;
      err          <= 1'b0;
      words_loaded <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            err          <= 1'b0;
            words_loaded <= '0;
          end
        end
        HDR0: begin
          if (hs) count[7:0] <= in_data;
        end
        HDR1: begin
          if (hs) begin
            count[15:8] <= in_data;
            idx         <= '0;
            addr        <= '0;
            if (oversize) err <= 1'b1;
          end
        end
        BYTE: begin
          if (hs) begin
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
              wr_data <= {in_data, word};
              wr_addr <= addr;
            end else begin
              word[{idx, 3'b000} +: 8] <= in_data;
            end
          end
        end
        WRITE: begin
          words_loaded <= words_loaded + 16'd1;
          if (!last_word) addr <= addr + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: stream-level reference model checked every cycle, plus directed literal checks.
module tb_imem_loader;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;
  logic [15:0]       words_loaded;

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: actual %h required %h", name, act, exp);
  endtask

  // Reference model: what each output must be in the current cycle, derived from accepted stream bytes.
  bit                m_busy, m_ready, m_wr, m_done, m_err;
  int                m_words, m_n, nacc;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_data;
  logic [7:0]        q[$];

  logic [ADDR_W-1:0] log_addr[$];
  logic [31:0]       log_data[$];
  int                log_lat[$];
  int                log_cyc[$];
  int                done_cnt, done_lat, hs_edge;

  always @(negedge clk) begin
    bit n_wr, n_done, n_ready, n_busy;
    if (!rst) begin
      m_busy = 0; m_ready = 0; m_wr = 0; m_done = 0; m_err = 0;
      m_words = 0; m_n = 0; nacc = 0; q.delete();
    end
    chk("wr_en", wr_en, m_wr);
    if (m_wr) begin
      chk("wr_addr", wr_addr, m_addr);
      chk("wr_data", wr_data, m_data);
    end
    chk("done", done, m_done);
    chk("busy", busy, m_busy);
    chk("cpu_hold", cpu_hold, m_busy);
    chk("in_ready", in_ready, m_ready);
    chk("err", err, m_err);
    chk("words_loaded", words_loaded, m_words);

    if (wr_en) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
      log_lat.push_back(cyc - hs_edge + 1);
      log_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_lat = cyc - hs_edge + 1;
    end

    if (rst) begin
      n_wr = 0; n_done = 0; n_ready = m_ready; n_busy = m_busy;
      if (!m_busy) begin
        if (start) begin
          n_busy = 1; n_ready = 1; m_err = 0; m_words = 0; nacc = 0; q.delete();
        end
      end else if (m_ready && in_valid) begin
        nacc++;
        q.push_back(in_data);
        if (nacc == 2) begin
          m_n = int'({q[1], q[0]});
          if (m_n == 0) begin
            n_ready = 0; n_done = 1;
          end else if (m_n > DEPTH) begin
            m_err = 1; n_busy = 0; n_ready = 0;
          end
        end else if (nacc > 2 && (nacc - 2) % 4 == 0) begin
          n_ready = 0; n_wr = 1;
          m_addr = ADDR_W'((nacc - 2) / 4 - 1);
          m_data = {q[nacc-1], q[nacc-2], q[nacc-3], q[nacc-4]};
        end
      end else if (m_wr) begin
        m_words++;
        if (int'(m_addr) == m_n - 1) n_done = 1;
        else n_ready = 1;
      end else if (m_done) begin
        n_busy = 0;
      end
      m_wr = n_wr; m_done = n_done; m_ready = n_ready; m_busy = n_busy;
    end
    if (in_valid && in_ready) hs_edge = cyc + 1;
  end

  logic [7:0] stim[$];

  task automatic send_byte(input logic [7:0] b, input int gap);
    in_valid = 1'b0;
    repeat (gap) begin
      in_data = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
    end
    chk("handshake_timeout", in_ready, 1);
    in_valid = 1'b0;
  endtask

  task automatic send_stim(input int gmin, input int gmax);
    foreach (stim[i]) send_byte(stim[i], $urandom_range(gmax, gmin));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (!busy) begin
        @(posedge clk); #1;
        return;
      end
    end
    chk("idle_timeout", busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic clear_logs();
    log_addr.delete(); log_data.delete(); log_lat.delete(); log_cyc.delete();
    done_cnt = 0; done_lat = -1;
  endtask

  task automatic check_basic_writes(input string tag);
    chk({tag, "_nwr"}, log_addr.size(), 2);
    if (log_addr.size() == 2) begin
      chk({tag, "_addr0"}, log_addr[0], 0);
      chk({tag, "_data0"}, log_data[0], 32'h20080020);
      chk({tag, "_lat0"},  log_lat[0], 1);
      chk({tag, "_addr1"}, log_addr[1], 1);
      chk({tag, "_data1"}, log_data[1], 32'h2009002A);
      chk({tag, "_lat1"},  log_lat[1], 1);
    end
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_words"}, words_loaded, 2);
    chk({tag, "_cpu_hold"}, cpu_hold, 0);
  endtask

  initial begin
    int n, kind;
    clear_logs();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_words", words_loaded, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Basic back-to-back load
    clear_logs();
    pulse_start();
    stim = '{8'h02, 8'h00, 8'h20, 8'h00, 8'h08, 8'h20, 8'h2A, 8'h00, 8'h09, 8'h20};
    send_stim(0, 0);
    wait_idle();
    check_basic_writes("t1");
    if (log_cyc.size() == 2) chk("t1_word_spacing", log_cyc[1] - log_cyc[0], 5);

    // Same stream with 3-cycle gaps between bytes
    clear_logs();
    pulse_start();
    send_stim(3, 3);
    wait_idle();
    check_basic_writes("t2");

    // Zero count
    clear_logs();
    pulse_start();
    stim = '{8'h00, 8'h00};
    send_stim(0, 1);
    wait_idle();
    chk("t3_nwr", log_addr.size(), 0);
    chk("t3_done_cnt", done_cnt, 1);
    chk("t3_done_lat", done_lat, 1);
    chk("t3_words", words_loaded, 0);
    chk("t3_err", err, 0);

    // Oversize count, then a clean load clears err
    clear_logs();
    pulse_start();
    stim = '{8'h01, 8'h04};
    send_stim(0, 0);
    chk("t4_busy_after", busy, 0);
    chk("t4_err", err, 1);
    @(posedge clk); #1;
    chk("t4_nwr", log_addr.size(), 0);
    chk("t4_done_cnt", done_cnt, 0);
    pulse_start();
    chk("t4_err_cleared", err, 0);
    stim = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    send_stim(0, 2);
    wait_idle();
    chk("t4_nwr2", log_addr.size(), 1);
    if (log_addr.size() == 1) chk("t4_data", log_data[0], 32'h12345678);
    chk("t4_err_end", err, 0);

    // Start while busy is ignored
    clear_logs();
    pulse_start();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    pulse_start();
    send_byte(8'h33, 0); send_byte(8'h44, 0);
    wait_idle();
    chk("t5_nwr", log_addr.size(), 1);
    if (log_addr.size() == 1) chk("t5_data", log_data[0], 32'h44332211);
    chk("t5_done_cnt", done_cnt, 1);

    // Asynchronous reset mid-load
    clear_logs();
    pulse_start();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    chk("t6_busy_before", busy, 1);
    #3 rst = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_cpu_hold", cpu_hold, 0);
    chk("t6_in_ready", in_ready, 0);
    chk("t6_wr_en", wr_en, 0);
    chk("t6_done", done, 0);
    chk("t6_words", words_loaded, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_idle", busy, 0);
    clear_logs();
    pulse_start();
    stim = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_stim(0, 1);
    wait_idle();
    chk("t6_nwr", log_addr.size(), 1);
    if (log_addr.size() == 1) begin
      chk("t6_addr", log_addr[0], 0);
      chk("t6_data", log_data[0], 32'hDEADBEEF);
    end

    // Full-depth load: last address must be DEPTH-1
    clear_logs();
    pulse_start();
    stim = '{8'h00, 8'h04};
    for (int i = 0; i < 4 * DEPTH; i++) stim.push_back(8'($urandom));
    send_stim(0, 0);
    wait_idle();
    chk("depth_nwr", log_addr.size(), DEPTH);
    if (log_addr.size() == DEPTH) chk("depth_last_addr", log_addr[DEPTH-1], DEPTH - 1);
    chk("depth_words", words_loaded, DEPTH);

    // Randomized programs, including zero and oversize counts
    for (int it = 0; it < 12; it++) begin
      kind = $urandom_range(7, 0);
      if (kind == 0)      n = 0;
      else if (kind == 1) n = DEPTH + 1 + $urandom_range(200, 0);
      else                n = $urandom_range(6, 1);
      stim.delete();
      stim.push_back(8'(n));
      stim.push_back(8'(n >> 8));
      if (n <= DEPTH)
        for (int i = 0; i < 4 * n; i++) stim.push_back(8'($urandom));
      pulse_start();
      send_stim(0, 2);
      wait_idle();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
